// File: rtl/decode_pkg.sv
// Shared opcodes, immediate-extension modes, FSM encodings and decode flags
// for the 16-bit CPU decode/issue stage.
package decode_pkg;

  localparam int XLEN = 16;
  localparam int NREG = 16;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [1:0] IMM_BR  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_SE8 = 2'b10;
  localparam logic [1:0] IMM_ZE8 = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  // src_a = rs[7:4], src_b = rt[3:0], src_d = field [11:8] read as a source
  typedef struct packed {
    logic [1:0] choice;
    logic       shft;
    logic       is_load;
    logic       dst_v;
    logic       src_a_v;
    logic       src_b_v;
    logic       src_d_v;
  } dec_t;

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Fetch->decode and decode->EX signal bundle; `DECODE_PERF_CNT_EN adds the
// performance counter outputs.
interface decode_issue_ctrl_if;
  import decode_pkg::*;

  // A beat moves on a side when its valid and ready are both high at the
  // clock edge; valid never waits on ready, and ready here ignores if_valid.
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic            id_ready;
  logic            flush;
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_instr;
  logic [XLEN-1:0] ex_imm;
  logic [1:0]      ex_imm_choice;
  logic            ex_imm_shft;
  logic            ex_is_load;
  logic [3:0]      ex_dst;
  logic            halted;
  state_t          dbg_state;
`ifdef DECODE_PERF_CNT_EN
  logic [15:0]     perf_stall_cnt;
  logic [15:0]     perf_flush_cnt;
`endif

  modport master (
    output if_valid, if_instr, flush, ex_ready,
    input  id_ready, ex_valid, ex_instr, ex_imm, ex_imm_choice, ex_imm_shft,
           ex_is_load, ex_dst, halted, dbg_state
`ifdef DECODE_PERF_CNT_EN
    , input perf_stall_cnt, perf_flush_cnt
`endif
  );

  modport slave (
    input  if_valid, if_instr, flush, ex_ready,
    output id_ready, ex_valid, ex_instr, ex_imm, ex_imm_choice, ex_imm_shft,
           ex_is_load, ex_dst, halted, dbg_state
`ifdef DECODE_PERF_CNT_EN
    , output perf_stall_cnt, perf_flush_cnt
`endif
  );

endinterface

// File: rtl/imm_ctrl_lut.sv
// Combinational opcode decode: extension mode, shift, load/dst/source flags,
// and the extended immediate.
module imm_ctrl_lut
  import decode_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output dec_t            dec,
  output logic [XLEN-1:0] imm
);

  logic [XLEN-1:0] ext;

  always_comb begin
    dec        = '0;
    dec.choice = IMM_SE8;
    unique case (instr[15:12])
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
        dec.dst_v = 1'b1; dec.src_a_v = 1'b1; dec.src_b_v = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        dec.choice = IMM_MEM; dec.dst_v = 1'b1; dec.src_a_v = 1'b1;
      end
      OP_LW: begin
        dec.choice = IMM_MEM; dec.shft = 1'b1; dec.is_load = 1'b1;
        dec.dst_v = 1'b1; dec.src_a_v = 1'b1;
      end
      OP_SW: begin
        dec.choice = IMM_MEM; dec.shft = 1'b1;
        dec.src_a_v = 1'b1; dec.src_d_v = 1'b1;
      end
      OP_LLB, OP_LHB: begin
        dec.choice = IMM_ZE8; dec.dst_v = 1'b1; dec.src_d_v = 1'b1;
      end
      OP_B:    dec.choice = IMM_BR;
      OP_BR:   dec.src_a_v = 1'b1;
      OP_PCS:  dec.dst_v = 1'b1;
      default: dec = dec;
    endcase
  end

  always_comb begin
    ext = '0;
    unique case (dec.choice)
      IMM_BR:  ext = {{6{instr[8]}}, instr[8:0], 1'b0};
      IMM_MEM: ext = {{12{instr[3]}}, instr[3:0]};
      IMM_SE8: ext = {{8{instr[7]}}, instr[7:0]};
      default: ext = {8'h00, instr[7:0]};
    endcase
    imm = dec.shft ? {ext[XLEN-2:0], 1'b0} : ext;
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller: ID/EX register, load-use bubbles, flush and halt.
// Optional `DECODE_PERF_CNT_EN adds saturating stall/flush counters.
module decode_issue_ctrl
  import decode_pkg::*;
(
  input logic                clk,
  input logic                rst,
  decode_issue_ctrl_if.slave bus
);

  dec_t            dec;
  logic [XLEN-1:0] imm;
  state_t          state_q, state_d;

  logic            ex_valid_q;
  logic [XLEN-1:0] ex_instr_q;
  logic [XLEN-1:0] ex_imm_q;
  logic [1:0]      ex_choice_q;
  logic            ex_shft_q;
  logic            ex_is_load_q;
  logic [3:0]      ex_dst_q;

  logic hazard, adv, id_ready, xfer, stall_evt;

  imm_ctrl_lut u_lut (
    .instr (bus.if_instr),
    .dec   (dec),
    .imm   (imm)
  );

  // R0 never hazards because a load to R0 registers ex_dst = 0
  assign hazard = ex_valid_q && ex_is_load_q && (ex_dst_q != 4'd0) &&
                  ((dec.src_a_v && (bus.if_instr[7:4]  == ex_dst_q)) ||
                   (dec.src_b_v && (bus.if_instr[3:0]  == ex_dst_q)) ||
                   (dec.src_d_v && (bus.if_instr[11:8] == ex_dst_q)));

  assign adv       = !ex_valid_q || bus.ex_ready;
  assign id_ready  = (state_q == ST_RUN) && !hazard && adv && !bus.flush;
  assign xfer      = bus.if_valid && id_ready;
  assign stall_evt = (state_q == ST_RUN) && bus.if_valid && hazard && adv && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (stall_evt)                                  state_d = ST_STALL;
        else if (xfer && (bus.if_instr[15:12] == OP_HLT)) state_d = ST_HALT;
      end
      ST_STALL: state_d = ST_RUN;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RUN;
    endcase
    if (bus.flush) state_d = ST_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_instr_q   <= '0;
      ex_imm_q     <= '0;
      ex_choice_q  <= IMM_BR;
      ex_shft_q    <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_dst_q     <= 4'd0;
    end else if (bus.flush) begin
      ex_valid_q   <= 1'b0;
    end else if (xfer) begin
      ex_valid_q   <= 1'b1;
      ex_instr_q   <= bus.if_instr;
      ex_imm_q     <= imm;
      ex_choice_q  <= dec.choice;
      ex_shft_q    <= dec.shft;
      ex_is_load_q <= dec.is_load;
      ex_dst_q     <= dec.dst_v ? bus.if_instr[11:8] : 4'd0;
    end else if (adv) begin
      ex_valid_q   <= 1'b0;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (bus.flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.perf_stall_cnt = stall_cnt_q;
  assign bus.perf_flush_cnt = flush_cnt_q;
`endif

  assign bus.id_ready      = id_ready;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_instr      = ex_instr_q;
  assign bus.ex_imm        = ex_imm_q;
  assign bus.ex_imm_choice = ex_choice_q;
  assign bus.ex_imm_shft   = ex_shft_q;
  assign bus.ex_is_load    = ex_is_load_q;
  assign bus.ex_dst        = ex_dst_q;
  assign bus.halted        = (state_q == ST_HALT);
  assign bus.dbg_state     = state_q;

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Decode-stage controller for the 16-bit CPU. Sits between the fetch output and the ID/EX pipeline register, with valid/ready handshakes on both sides.
- Classifies each opcode and selects the immediate-extension mode and shift. Produces the extended immediate, detects load-use hazards and inserts bubbles.
- Handles flushes from branch resolution and the halt sequence.

Parameters:
- XLEN, 16, instruction and immediate width.
- NREG, 16, architectural register count; R0 is hardwired zero and never causes a hazard.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- if_valid  in  1  fetch presents if_instr
- if_instr  in  16  fetched instruction
- id_ready  out  1  decode accepts if_instr this cycle
- flush  in  1  EX redirect; kill the ID slot and the EX-register contents
- ex_ready  in  1  EX consumes the register contents
- ex_valid  out  1  ID/EX register holds a real instruction
- ex_instr  out  16  registered instruction
- ex_imm  out  16  registered extended immediate
- ex_imm_choice  out  2  registered extension mode (00 branch, 01 mem/4-bit, 10 sext8, 11 zext8)
- ex_imm_shft  out  1  registered post-extension left shift by 1
- ex_is_load  out  1  registered: instruction is LW
- ex_dst  out  4  registered destination register (0 if none)
- halted  out  1  HLT has issued

Behaviour:
- Opcode field [15:12]:
  - 0-3 ADD/SUB/XOR/RED: rd[11:8], rs[7:4], rt[3:0].
  - 4-6 SLL/SRA/ROR: rd, rs; imm4 uses choice 01, shft 0.
  - 7 PADDSB: as ALU.
  - 8 LW: rd[11:8], base rs[7:4]; choice 01, shft 1.
  - 9 SW: data [11:8] is a source, base rs; choice 01, shft 1; dst 0.
  - A/B LLB/LHB: rd is both source and destination; choice 11, shft 0.
  - C B: choice 00, shft 0; no register sources.
  - D BR: source rs[7:4].
  - E PCS: rd.
  - F HLT: no registers.
- For opcodes without an immediate, choice is 10 and shft 0; ex_imm is don't-care but deterministic.
- Extension rules:
  - 00: sext(instr[8:0]) then <<1.
  - 01: sext(instr[3:0]).
  - 10: sext(instr[7:0]).
  - 11: zext(instr[7:0]).
  - shft=1 applies a further <<1. All results are truncated to 16 bits.
- Load-use hazard: ex_valid and ex_is_load and ex_dst!=0, and ex_dst equals any source of if_instr.
- adv = !ex_valid || ex_ready.
- id_ready = (state==RUN) && !hazard && adv && !flush. This is combinational; if_valid does not affect it.
- Transfer occurs when if_valid && id_ready. On the next edge the register loads the decoded fields and ex_valid=1.
- When adv but no transfer: ex_valid<=0. This covers both a bubble and an empty fetch.
- When !adv: all ex_* outputs hold.
- flush has top priority: next edge ex_valid<=0, the incoming instruction is discarded, and state returns to RUN from any state.
- FSM (2-bit): RUN, STALL, HALT.
  - RUN -> STALL when if_valid && hazard && adv. The bubble goes into EX.
  - STALL -> RUN after one cycle. The hazard has cleared because the load has left EX.
  - RUN -> HALT on transfer of an HLT without flush. halted=1 from the next edge.
  - In HALT, id_ready=0 until flush or rst.
- Reset (async): state=RUN, ex_valid=0, ex_instr=0, ex_imm=0, ex_imm_choice=00, ex_imm_shft=0, ex_is_load=0, ex_dst=0, halted=0.
- Simultaneous events:
  - flush with hazard: flush wins, no STALL entry.
  - flush with HLT transfer: the HLT is dropped and the state stays RUN.
- If reset asserts mid-stall, the state machine and register clear immediately.

Optional Feature:
- Macro DECODE_PERF_CNT_EN. When defined, adds outputs perf_stall_cnt[15:0] and perf_flush_cnt[15:0]. Both are saturating counters, reset to 0.
  - perf_stall_cnt increments each cycle a load-use bubble is inserted.
  - perf_flush_cnt increments on each flush cycle.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams OP_ADD..OP_HLT;
  - immediate-mode constants IMM_BR=2'b00, IMM_MEM=2'b01, IMM_SE8=2'b10, IMM_ZE8=2'b11;
  - FSM state encodings ST_RUN, ST_STALL, ST_HALT.
- One sub-module, imm_ctrl_lut: purely combinational. It maps an opcode to choice, shft, is_load, dst-valid and source-valid flags, and computes ex_imm.

Test Plan:
- LW 0x8322 accepted with ex_ready=1 -> next cycle ex_valid=1, ex_imm_choice=01, ex_imm_shft=1, ex_imm=0x0004, ex_is_load=1, ex_dst=3.
- LW 0x8322 then ADD 0x0431 -> one cycle with id_ready=0 and ex_valid=0 (bubble), then ADD issues; in the DECODE_PERF_CNT_EN build, perf_stall_cnt=1.
- B 0xC1FF -> ex_imm=0xFFFE, choice 00. LLB 0xA580 -> ex_imm=0x0080, choice 11.
- ex_ready=0 for 3 cycles with an ADD held -> ex_* stable, id_ready=0; release -> the next instruction loads.
- HLT 0xF000 issues -> halted=1, id_ready=0 despite if_valid. Then flush=1 -> ex_valid=0, halted=0, RUN.
- rst pulsed mid-STALL -> all outputs at reset values asynchronously; accepts an instruction the first cycle after release.
